// File: rtl/mips_cpu_muldiv_if.sv
// HI/LO multiply-divide unit request/result bundle.
// The CPU side is the master, the arithmetic unit is the slave.
interface mips_cpu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             divzero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, divzero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, divzero, hi, lo
  );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// Iterative MIPS HI/LO unit: MULT/MULTU/DIV/DIVU in WIDTH cycles
// plus a sign-fix cycle; MTHI/MTLO write HI/LO directly.
module mips_cpu_muldiv #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic clk,
  input  logic rst_n,
  mips_cpu_muldiv_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mb;
  logic [WIDTH-1:0]   r_a;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz_pend;
  logic               r_busy;
  logic               r_done;
  logic               r_divzero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_arith;
  logic               w_mthi;
  logic               w_mtlo;
  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;

  assign w_arith  = ~bus.op[2];
  assign w_mthi   = bus.op == 3'b100;
  assign w_mtlo   = bus.op == 3'b101;
  assign w_signed = ~bus.op[0];
  assign w_sa     = w_signed & bus.a[WIDTH-1];
  assign w_sb     = w_signed & bus.b[WIDTH-1];
  assign w_ma     = w_sa ? -bus.a : bus.a;
  assign w_mb     = w_sb ? -bus.b : bus.b;

  // Multiply: upper half accumulates, multiplier shifts out of bit 0.
  logic [WIDTH:0]     w_madd;
  logic [WIDTH:0]     w_mhi;
  logic [2*WIDTH-1:0] w_mnext;

  assign w_madd  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, r_mb};
  assign w_mhi   = r_acc[0] ? w_madd
                 : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
  assign w_mnext = {w_mhi, r_acc[WIDTH-1:1]};

  // Divide: remainder in the upper half, dividend/quotient below.
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_dnext;

  assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_mb};
  assign w_qbit  = ~w_diff[WIDTH];
  assign w_rem   = w_qbit ? w_diff[WIDTH-1:0]
                 : w_shift[WIDTH-1:0];
  assign w_dnext = {w_rem, r_acc[WIDTH-2:0], w_qbit};

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rmd;

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0]
                : r_acc[WIDTH-1:0];
  assign w_rmd  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH]
                : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mb      <= '0;
      r_a       <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz_pend <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            unique case (1'b1)
              w_arith: begin
                r_acc     <= {{WIDTH{1'b0}}, w_ma};
                r_mb      <= w_mb;
                r_a       <= bus.a;
                r_is_div  <= bus.op[1];
                r_neg_q   <= w_sa ^ w_sb;
                r_neg_r   <= w_sa;
                r_dz_pend <= bus.op[1] & (bus.b == '0);
                r_divzero <= 1'b0;
                r_cnt     <= '0;
                r_busy    <= 1'b1;
                r_state   <= S_RUN;
              end
              w_mthi:  r_hi <= bus.a;
              w_mtlo:  r_lo <= bus.a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_acc <= r_is_div ? w_dnext : w_mnext;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          // Divide by zero reports the raw dividend, not a magnitude.
          if (r_dz_pend) begin
            r_hi <= r_a;
            r_lo <= '1;
          end else if (r_is_div) begin
            r_hi <= w_rmd;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_divzero <= r_dz_pend;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.divzero = r_divzero;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;

endmodule

// File: doc/mips_cpu_muldiv.md
MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

Interface
REQ-001 Parameter: WIDTH, 32, operand/HI/LO width in bits; legal values 8..64, even.
REQ-002 Parameter: CNT_W, $clog2(WIDTH)+1, iteration counter width; derived and not overridden.
REQ-003 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: start  input  1  request strobe; sampled with op/a/b on the same edge.
REQ-006 Port: op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-007 Port: a  input  WIDTH  multiplicand/dividend, or MTHI/MTLO data.
REQ-008 Port: b  input  WIDTH  multiplier/divisor.
REQ-009 Port: busy  output  1  high while an arithmetic operation is in progress.
REQ-010 Port: done  output  1  one-cycle pulse: hi/lo now hold a new arithmetic result.
REQ-011 Port: hi  output  WIDTH  HI register: product upper half or remainder.
REQ-012 Port: lo  output  WIDTH  LO register: product lower half or quotient.
REQ-013 Port: divzero  output  1  set by a DIV/DIVU with b==0; holds until next accepted arithmetic op.

Function
REQ-014 FSM states: IDLE, RUN, FIX; only IDLE accepts start.
REQ-015 IDLE, start=1, op MULT/MULTU/DIV/DIVU: latch operand magnitudes and sign flags, clear counter and divzero, enter RUN, busy=1 from next cycle.
REQ-016 IDLE, start=1, op MTHI/MTLO: write a into hi/lo on that edge, stay IDLE; no busy, no done.
REQ-017 IDLE, start=1, op 110/111: no state change.
REQ-018 start while busy=1 is ignored; inputs are not latched.
REQ-019 RUN: exactly WIDTH iterations, one per cycle (multiply shift-add, or restoring divide one quotient bit); then FIX.
REQ-020 FIX: one cycle applies sign correction, writes hi/lo, pulses done, returns to IDLE with busy=0.
REQ-021 Latency: done high in the cycle after edge N+WIDTH+1, where N is the accepting edge; busy high for exactly WIDTH+1 cycles.
REQ-022 hi/lo hold previous values throughout RUN; partial results stay internal.
REQ-023 MULTU: {hi,lo} = unsigned a*b, full 2*WIDTH bits.
REQ-024 MULT: {hi,lo} = two's-complement a*b, full 2*WIDTH bits; magnitude product negated when sign(a) xor sign(b).
REQ-025 DIVU: lo = a/b, hi = a%b, unsigned.
REQ-026 DIV: quotient truncated toward zero; remainder has sign of a; |hi| < |b|.
REQ-027 DIV with a = most-negative and b = -1: lo = most-negative, hi = 0, divzero=0.
REQ-028 DIV/DIVU with b==0: full latency preserved; lo = all ones, hi = a, divzero=1 with done.
REQ-029 start accepted in the done cycle (state already IDLE); back-to-back ops have no bubble.
REQ-030 done never asserts for MTHI/MTLO, no-ops or ignored starts.

Reset
REQ-031 rst_n=0 at a rising edge: state IDLE, counter 0, busy=0, done=0, divzero=0, hi=0, lo=0.
REQ-032 Reset mid-RUN or in FIX aborts the operation; no done pulse and no hi/lo update.
REQ-033 start is ignored on any edge where rst_n=0.

Verification
REQ-034 WIDTH=32, MULT a=7, b=-3 -> done after 33 edges; hi=FFFFFFFF, lo=FFFFFFEB; busy high 33 cycles.
REQ-035 MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-036 DIV a=-7, b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1); DIVU a=7, b=2 -> lo=3, hi=1.
REQ-037 DIVU a=1234, b=0 -> lo=FFFFFFFF, hi=000004D2, divzero=1; next MULTU clears divzero on accept.
REQ-038 MTHI a=DEADBEEF; then MULT started, then a second start during busy -> hi=DEADBEEF until first done; second start is ignored.
REQ-039 DIV started, rst_n low at iteration 10 -> no done; hi=lo=0; WIDTH=8 rerun of REQ-034 case -> done after 9 edges, hi=FF, lo=EB.
